io_bus_arb: RTL and testbench
=============================

// Module: io_bus_arb
// PURPOSE
//  Shares the AVR core I/O peripheral bus (adr/iore/iowe/dbus) between the CPU core and a debug requester.
//  Core accesses pass through with zero latency; debug accesses are scheduled into core-idle cycles.
//  A debug access is forced, by stalling the core for one cycle, after a bounded wait.
//  Also merges the N peripheral read buses (dbus_out/out_en pairs) into one read-data bus.
// PARAMETERS
//  N_SRC      4   number of peripheral read sources (dbus_out/out_en pairs)
//  STARVE_MAX 15  debug wait cycles before core is stalled to force a slot (1..255)
// PORTS
//  cp2           in   1        clock, rising edge
//  ireset        in   1        reset, asynchronous, active-low
//  core_adr      in   6        core I/O address
//  core_iore     in   1        core I/O read strobe
//  core_iowe     in   1        core I/O write strobe
//  core_wdata    in   8        core write data
//  core_rdata    out  8        merged read data to core
//  core_stall    out  1        core must hold current access this cycle
//  io_adr        out  6        peripheral bus address
//  io_iore       out  1        peripheral bus read strobe
//  io_iowe       out  1        peripheral bus write strobe
//  io_wdata      out  8        peripheral bus write data
//  src_dbus      in   8*N_SRC  peripheral read data, source i at [8i+7:8i]
//  src_out_en    in   N_SRC    peripheral read-drive enables
//  dbg_req       in   1        debug access request, level, held until dbg_ack
//  dbg_we        in   1        1 = write, 0 = read; stable while dbg_req
//  dbg_adr       in   6        debug address; stable while dbg_req
//  dbg_wdata     in   8        debug write data; stable while dbg_req
//  dbg_ack       out  1        one-cycle completion pulse
//  dbg_rdata     out  8        debug read data, valid with dbg_ack, held until next ack
//  err_multi_drv out  1        sticky: >1 src_out_en active in one cycle (IO_ARB_ERR_EN only)
//  err_clr       in   1        clears err_multi_drv (IO_ARB_ERR_EN only)
// BEHAVIOUR
//  FSM states: IDLE, GNT, ACK. Reset -> IDLE.
//  Reset values: dbg_ack=0, dbg_rdata=8'h00, wait_cnt=0, err_multi_drv=0.
//  IDLE: io_* = core_* combinationally; core_stall=0. With dbg_req=1:
//   - core_iore=core_iowe=0 -> next state GNT.
//   - Core busy -> wait_cnt++. When wait_cnt==STARVE_MAX, next state GNT regardless of core.
//   - Debug access is never issued in the IDLE cycle itself.
//  GNT (exactly 1 cycle):
//   - io_adr=dbg_adr, io_iowe=dbg_we, io_iore=~dbg_we, io_wdata=dbg_wdata; core_stall=1.
//   - Core strobes are blocked; core holds its access and retries.
//   - At the edge: dbg_rdata <= merged read data (reads only), wait_cnt <= 0, next state ACK.
//  ACK (1 cycle): dbg_ack=1; io_* = core_*; core_stall=0; dbg_req ignored; next state IDLE.
//   - dbg_req still high in the following IDLE cycle is a new request.
//  Latency: 2 cycles dbg_req->dbg_ack when the core is idle; max STARVE_MAX+2 cycles.
//  Read merge: OR of src_dbus slices whose src_out_en=1; none enabled -> 8'h00.
//   - core_rdata is driven in every state (stall cycles included).
//  Reset mid-operation: FSM -> IDLE, pending debug access dropped, no ack issued.
//  dbg_req dropped before ack: protocol violation; the access in flight still completes.
// CONFIGURATION
//  IO_ARB_ERR_EN defined:
//   - Any cycle with popcount(src_out_en)>1 sets err_multi_drv at the next edge.
//   - err_clr=1 clears it; if set and clear occur in the same cycle, set wins.
//   - Read data is still the OR merge.
//  Not defined: err_multi_drv tied 0, err_clr ignored, no detection logic.
// STRUCTURE
//  io_arb_pkg: state encoding (IDLE/GNT/ACK), RD_IDLE_DATA=8'h00, wait-counter width (8).
//  Sub-module io_rd_mux: parameterised N_SRC OR-merge; drives the multi-drive detect under the macro.
// TESTING
//  1. Core idle, dbg read adr=6'h13, source1 out_en returns 8'h41
//     -> GNT next cycle, dbg_ack 2 cycles after req, dbg_rdata=8'h41.
//  2. Core issuing iore every cycle, dbg write adr=6'h13 data 8'h00, STARVE_MAX=15
//     -> 15 wait cycles, core_stall=1 for 1 cycle with io_iowe=1, then ack.
//  3. Core read adr=6'h20 with no src_out_en -> core_rdata=8'h00, core_stall=0, zero latency.
//  4. src_out_en=4'b0011 with IO_ARB_ERR_EN
//     -> err_multi_drv=1 next cycle, stays set; err_clr=1 clears it.
//     Without the macro -> stays 0.
//  5. ireset asserted during GNT -> IDLE, dbg_ack never pulses, dbg_rdata=8'h00.
//  6. dbg_req held high across ack -> second access starts from IDLE, two acks 3 cycles apart.

Source files
------------

// File: rtl/io_arb_pkg.sv
// rtl/io_arb_pkg.sv - shared types and constants for the I/O bus arbiter
package io_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT  = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_e;

    localparam logic [7:0] RD_IDLE_DATA = 8'h00;
    localparam int         WAIT_W       = 8;

endpackage

// File: rtl/io_rd_mux.sv
// rtl/io_rd_mux.sv - OR-merge of peripheral read buses; multi-drive detect under IO_ARB_ERR_EN
module io_rd_mux
    import io_arb_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [8*N_SRC-1:0] src_dbus,
    input  logic [N_SRC-1:0]   src_out_en,
    output logic [7:0]         rdata,
    output logic               multi_drv
);

    logic seen;
    logic multi;

    always_comb begin
        rdata = RD_IDLE_DATA;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_out_en[i]) begin
                rdata = rdata | src_dbus[8*i +: 8];
            end
            multi = multi | (seen & src_out_en[i]);
            seen  = seen | src_out_en[i];
        end
    end

`ifdef IO_ARB_ERR_EN
    assign multi_drv = multi;
`else
    logic unused_multi;
    assign unused_multi = multi;
    assign multi_drv    = 1'b0;
`endif

endmodule

// File: rtl/io_bus_arb.sv
// rtl/io_bus_arb.sv - core/debug I/O bus arbiter with read merge; IO_ARB_ERR_EN adds multi-drive error flag
module io_bus_arb
    import io_arb_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int STARVE_MAX = 15
) (
    input  logic               cp2,
    input  logic               ireset,
    input  logic [5:0]         core_adr,
    input  logic               core_iore,
    input  logic               core_iowe,
    input  logic [7:0]         core_wdata,
    output logic [7:0]         core_rdata,
    output logic               core_stall,
    output logic [5:0]         io_adr,
    output logic               io_iore,
    output logic               io_iowe,
    output logic [7:0]         io_wdata,
    input  logic [8*N_SRC-1:0] src_dbus,
    input  logic [N_SRC-1:0]   src_out_en,
    input  logic               dbg_req,
    input  logic               dbg_we,
    input  logic [5:0]         dbg_adr,
    input  logic [7:0]         dbg_wdata,
    output logic               dbg_ack,
    output logic [7:0]         dbg_rdata,
    output logic               err_multi_drv,
    input  logic               err_clr
);

    localparam logic [WAIT_W-1:0] STARVE_LIM = WAIT_W'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [7:0]        merged;
    logic              multi_drv;

    io_rd_mux #(.N_SRC(N_SRC)) u_rd_mux (
        .src_dbus   (src_dbus),
        .src_out_en (src_out_en),
        .rdata      (merged),
        .multi_drv  (multi_drv)
    );

    assign core_rdata = merged;
    assign dbg_rdata  = rdata_q;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        rdata_d    = rdata_q;
        io_adr     = core_adr;
        io_iore    = core_iore;
        io_iowe    = core_iowe;
        io_wdata   = core_wdata;
        core_stall = 1'b0;
        dbg_ack    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The starvation bound takes the slot even while the core is mid-access.
                if (dbg_req) begin
                    if ((!core_iore && !core_iowe) || (wait_q == STARVE_LIM)) begin
                        state_d = ST_GNT;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            ST_GNT: begin
                io_adr     = dbg_adr;
                io_iowe    = dbg_we;
                io_iore    = ~dbg_we;
                io_wdata   = dbg_wdata;
                core_stall = 1'b1;
                if (!dbg_we) begin
                    rdata_d = merged;
                end
                wait_d  = '0;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                dbg_ack = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            rdata_q <= RD_IDLE_DATA;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef IO_ARB_ERR_EN
    logic err_q;

    // A new multi-drive event outranks a simultaneous clear.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            err_q <= 1'b0;
        end else if (multi_drv) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err_multi_drv = err_q;
`else
    logic unused_err;
    assign unused_err    = err_clr ^ multi_drv;
    assign err_multi_drv = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_arb.sv
// tb/tb_io_bus_arb.sv - scoreboard bench for io_bus_arb
module tb_io_bus_arb;

    localparam int N_SRC      = 4;
    localparam int STARVE_MAX = 15;
`ifdef IO_ARB_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic               cp2 = 1'b0;
    logic               ireset = 1'b0;
    logic [5:0]         core_adr = '0;
    logic               core_iore = 1'b0;
    logic               core_iowe = 1'b0;
    logic [7:0]         core_wdata = '0;
    logic [7:0]         core_rdata;
    logic               core_stall;
    logic [5:0]         io_adr;
    logic               io_iore;
    logic               io_iowe;
    logic [7:0]         io_wdata;
    logic [8*N_SRC-1:0] src_dbus = '0;
    logic [N_SRC-1:0]   src_out_en = '0;
    logic               dbg_req = 1'b0;
    logic               dbg_we = 1'b0;
    logic [5:0]         dbg_adr = '0;
    logic [7:0]         dbg_wdata = '0;
    logic               dbg_ack;
    logic [7:0]         dbg_rdata;
    logic               err_multi_drv;
    logic               err_clr = 1'b0;

    io_bus_arb #(.N_SRC(N_SRC), .STARVE_MAX(STARVE_MAX)) dut (
        .cp2           (cp2),
        .ireset        (ireset),
        .core_adr      (core_adr),
        .core_iore     (core_iore),
        .core_iowe     (core_iowe),
        .core_wdata    (core_wdata),
        .core_rdata    (core_rdata),
        .core_stall    (core_stall),
        .io_adr        (io_adr),
        .io_iore       (io_iore),
        .io_iowe       (io_iowe),
        .io_wdata      (io_wdata),
        .src_dbus      (src_dbus),
        .src_out_en    (src_out_en),
        .dbg_req       (dbg_req),
        .dbg_we        (dbg_we),
        .dbg_adr       (dbg_adr),
        .dbg_wdata     (dbg_wdata),
        .dbg_ack       (dbg_ack),
        .dbg_rdata     (dbg_rdata),
        .err_multi_drv (err_multi_drv),
        .err_clr       (err_clr)
    );

    always #5 cp2 = ~cp2;

    int cyc = 0;
    always @(posedge cp2) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] rdata;
        int         cycle;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack pops one expectation
    always @(negedge cp2) begin
        if (ireset && dbg_ack) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_rdata", 32'(dbg_rdata), 32'(e.rdata));
                check("ack_cycle", 32'(cyc), 32'(e.cycle));
            end
        end
    end

    task automatic dbg_access(input logic we, input logic [5:0] adr, input logic [7:0] wd,
                              input logic [7:0] exp_rd, input int latency);
        bit acked;
        sb.push_back('{exp_rd, cyc + latency});
        dbg_we    = we;
        dbg_adr   = adr;
        dbg_wdata = wd;
        dbg_req   = 1'b1;
        acked     = 1'b0;
        for (int i = 0; i < 40 && !acked; i++) begin
            @(posedge cp2);
            #1;
            if (dbg_ack) acked = 1'b1;
        end
        dbg_req = 1'b0;
        if (!acked) begin
            n_checks++;
            n_errors++;
            $display("FAIL dbg_ack_timeout: got no ack expected ack within 40 cycles");
            void'(sb.pop_back());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge cp2);
        #1;
        check("rst_ack", 32'(dbg_ack), 0);
        check("rst_rdata", 32'(dbg_rdata), 0);
        check("rst_err", 32'(err_multi_drv), 0);
        check("rst_stall", 32'(core_stall), 0);
        ireset = 1'b1;
        @(posedge cp2);
        #1;

        // 1: core idle, debug read from source 1
        src_dbus   = {8'h0C, 8'h30, 8'h41, 8'h03};
        src_out_en = 4'b0010;
        fork
            dbg_access(1'b0, 6'h13, 8'h00, 8'h41, 2);
            begin
                @(negedge cp2);
                check("t1_idle_stall", 32'(core_stall), 0);
                @(negedge cp2);
                check("t1_gnt_stall", 32'(core_stall), 1);
                check("t1_gnt_iore", 32'(io_iore), 1);
                check("t1_gnt_iowe", 32'(io_iowe), 0);
                check("t1_gnt_adr", 32'(io_adr), 32'h13);
            end
        join
        src_out_en = 4'b0000;
        @(posedge cp2);
        #1;

        // 3: core read, zero latency, merge
        core_adr  = 6'h20;
        core_iore = 1'b1;
        #1;
        check("t3_rdata_none", 32'(core_rdata), 0);
        check("t3_stall", 32'(core_stall), 0);
        check("t3_io_adr", 32'(io_adr), 32'h20);
        check("t3_io_iore", 32'(io_iore), 1);
        src_out_en = 4'b1001;
        #1;
        check("t3_rdata_or", 32'(core_rdata), 32'h0F);
        src_out_en = 4'b0000;
        @(posedge cp2);
        #1;

        // 2: core reads every cycle, debug write forced after the starvation bound
        core_adr = 6'h05;
        fork
            dbg_access(1'b1, 6'h13, 8'h00, 8'h41, STARVE_MAX + 2);
            begin
                for (int k = 0; k <= STARVE_MAX + 1; k++) begin
                    @(negedge cp2);
                    check("t2_stall", 32'(core_stall), 32'(k == STARVE_MAX + 1));
                    if (k == STARVE_MAX + 1) begin
                        check("t2_iowe", 32'(io_iowe), 1);
                        check("t2_iore", 32'(io_iore), 0);
                        check("t2_adr", 32'(io_adr), 32'h13);
                        check("t2_wdata", 32'(io_wdata), 0);
                    end
                end
            end
        join
        core_iore = 1'b0;
        @(posedge cp2);
        #1;

        // 4: multi-drive flag
        src_out_en = 4'b0011;
        @(posedge cp2);
        #1;
        src_out_en = 4'b0000;
        check("t4_err_set", 32'(err_multi_drv), 32'(ERR_EN));
        @(posedge cp2);
        #1;
        check("t4_err_sticky", 32'(err_multi_drv), 32'(ERR_EN));
        err_clr = 1'b1;
        @(posedge cp2);
        #1;
        check("t4_err_clr", 32'(err_multi_drv), 0);
        src_out_en = 4'b0011;
        @(posedge cp2);
        #1;
        src_out_en = 4'b0000;
        check("t4_set_wins", 32'(err_multi_drv), 32'(ERR_EN));
        @(posedge cp2);
        #1;
        err_clr = 1'b0;
        check("t4_err_clr2", 32'(err_multi_drv), 0);

        // 6: request held across ack, second access from IDLE
        src_dbus   = {8'h0C, 8'h5A, 8'h41, 8'h03};
        src_out_en = 4'b0100;
        sb.push_back('{8'h5A, cyc + 2});
        sb.push_back('{8'h66, cyc + 5});
        dbg_we  = 1'b0;
        dbg_adr = 6'h2A;
        dbg_req = 1'b1;
        repeat (2) @(posedge cp2);
        #1;
        src_dbus[23:16] = 8'h66;
        repeat (3) @(posedge cp2);
        #1;
        dbg_req = 1'b0;
        repeat (3) @(posedge cp2);
        #1;

        // 5: reset during GNT drops the access
        dbg_req = 1'b1;
        @(posedge cp2);
        #1;
        check("t5_in_gnt", 32'(core_stall), 1);
        #2;
        ireset = 1'b0;
        #1;
        dbg_req = 1'b0;
        check("t5_rdata", 32'(dbg_rdata), 0);
        check("t5_stall", 32'(core_stall), 0);
        check("t5_ack", 32'(dbg_ack), 0);
        @(posedge cp2);
        #1;
        ireset = 1'b1;
        repeat (4) @(posedge cp2);
        #1;
        check("t5_rdata_after", 32'(dbg_rdata), 0);
        check("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
